// File: rtl/sram_access_ctrl.sv
// Two-requester round-robin access controller for the serial-load SRAM.
// Writes are shifted MSB-first and then strobed; reads strobe r_en and wait
// for data_valid under a timeout. Every output is registered.
module sram_access_ctrl #(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned BIT_CYCLES = 2,
  parameter int unsigned RD_TIMEOUT = 15,
  localparam int unsigned ADDR_W    = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                arst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*COLS-1:0]   req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [COLS-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic                sram_serial_in,
  output logic                sram_shift,
  output logic                sram_w_en,
  output logic                sram_r_en,
  output logic [ADDR_W-1:0]   sram_addr,
  input  logic                sram_data_valid,
  input  logic [COLS-1:0]     sram_data_out
);

  localparam int unsigned HOLD_W = $clog2(BIT_CYCLES + 1);
  localparam int unsigned BIT_W  = $clog2(COLS + 1);
  localparam int unsigned WAIT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    WAIT  = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t              state;
  logic                last_grant;
  logic                grant;
  logic [COLS-1:0]     shreg;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [WAIT_W-1:0]   wait_cnt;

  logic                gnt_c;
  logic                sel_we_c;
  logic [ADDR_W-1:0]   sel_addr_c;
  logic [COLS-1:0]     sel_wdata_c;

  // Round-robin pick and payload mux for the requester that would be granted now
  always_comb begin
    gnt_c = 1'b0;
    if (req_valid == 2'b11) begin
      gnt_c = ~last_grant;
    end else begin
      gnt_c = req_valid[1];
    end
    sel_we_c    = gnt_c ? req_we[1] : req_we[0];
    sel_addr_c  = gnt_c ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_wdata_c = gnt_c ? req_wdata[2*COLS-1:COLS] : req_wdata[COLS-1:0];
  end

  // Transaction FSM; outputs are loaded with the values of the state being entered
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      grant          <= 1'b0;
      shreg          <= '0;
      hold_cnt       <= '0;
      bit_cnt        <= '0;
      wait_cnt       <= '0;
      req_ready      <= '0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      busy           <= 1'b0;
      sram_serial_in <= 1'b0;
      sram_shift     <= 1'b0;
      sram_w_en      <= 1'b0;
      sram_r_en      <= 1'b0;
      sram_addr      <= '0;
    end else begin
      // single-cycle pulses
      req_ready <= '0;
      rsp_valid <= '0;
      sram_w_en <= 1'b0;
      sram_r_en <= 1'b0;

      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant      <= gnt_c;
            last_grant <= gnt_c;
            req_ready  <= gnt_c ? 2'b10 : 2'b01;
            sram_addr  <= sel_addr_c;
            busy       <= 1'b1;
            if (sel_we_c) begin
              state          <= SHIFT;
              shreg          <= sel_wdata_c;
              sram_shift     <= 1'b1;
              sram_serial_in <= sel_wdata_c[COLS-1];
              hold_cnt       <= '0;
              bit_cnt        <= '0;
            end else begin
              state     <= READ;
              sram_r_en <= 1'b1;
            end
          end
        end

        SHIFT: begin
          if (hold_cnt == HOLD_W'(BIT_CYCLES - 1)) begin
            hold_cnt <= '0;
            if (bit_cnt == BIT_W'(COLS - 1)) begin
              state          <= WRITE;
              sram_shift     <= 1'b0;
              sram_serial_in <= 1'b0;
              sram_w_en      <= 1'b1;
            end else begin
              bit_cnt        <= bit_cnt + 1'b1;
              shreg          <= shreg << 1;
              sram_serial_in <= shreg[COLS-2];
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        WRITE: begin
          state     <= RESP;
          rsp_valid <= grant ? 2'b10 : 2'b01;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end

        READ: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end

        // data_valid is checked before the timeout so a late-but-in-window reply wins
        WAIT: begin
          if (sram_data_valid) begin
            state     <= RESP;
            rsp_valid <= grant ? 2'b10 : 2'b01;
            rsp_rdata <= sram_data_out;
            rsp_err   <= 1'b0;
          end else if (wait_cnt == WAIT_W'(RD_TIMEOUT - 1)) begin
            state     <= RESP;
            rsp_valid <= grant ? 2'b10 : 2'b01;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end

        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          sram_shift     <= 1'b0;
          sram_serial_in <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Randomised and directed bench for sram_access_ctrl. Expected cycle-by-cycle
// behaviour is computed from the transaction timing rules (offsets from the
// accept cycle) and a round-robin grant model.
module tb_sram_access_ctrl;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;
  localparam int unsigned BC   = 2;
  localparam int unsigned RT   = 15;
  localparam int unsigned AW   = 3;

  logic            clk = 1'b0;
  logic            arst;
  logic [1:0]      req_valid;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*COLS-1:0] req_wdata;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [COLS-1:0] rsp_rdata;
  logic            rsp_err;
  logic            busy;
  logic            sram_serial_in;
  logic            sram_shift;
  logic            sram_w_en;
  logic            sram_r_en;
  logic [AW-1:0]   sram_addr;
  logic            sram_data_valid;
  logic [COLS-1:0] sram_data_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit lg;   // model: last granted requester

  sram_access_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .BIT_CYCLES(BC), .RD_TIMEOUT(RT)
  ) dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .sram_serial_in(sram_serial_in), .sram_shift(sram_shift),
    .sram_w_en(sram_w_en), .sram_r_en(sram_r_en), .sram_addr(sram_addr),
    .sram_data_valid(sram_data_valid), .sram_data_out(sram_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_rspv"},  32'(rsp_valid), 0);
    chk({tag, "_rdata"}, 32'(rsp_rdata), 0);
    chk({tag, "_err"},   32'(rsp_err), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_ser"},   32'(sram_serial_in), 0);
    chk({tag, "_shift"}, 32'(sram_shift), 0);
    chk({tag, "_wen"},   32'(sram_w_en), 0);
    chk({tag, "_ren"},   32'(sram_r_en), 0);
    chk({tag, "_addr"},  32'(sram_addr), 0);
  endtask

  // One complete transaction starting in an IDLE cycle (T = current cycle).
  // d: read reply offset (valid seen in cycle T+1+d), 0 = never (timeout).
  // noise: random data_valid pulses during a write's shift phase.
  task automatic run_txn(input logic [1:0] v, input logic [1:0] we,
                         input logic [2*AW-1:0] ad, input logic [2*COLS-1:0] wd,
                         input int d, input logic [COLS-1:0] rv, input bit noise);
    int g;
    int last;
    int idx;
    logic [1:0] oh;
    logic w;
    logic [AW-1:0] a;
    logic [COLS-1:0] dat;
    logic e_sh, e_ser, e_wen, e_ren, e_err;
    logic [1:0] e_rspv;
    logic [COLS-1:0] e_rd;

    chk("start_busy", 32'(busy), 0);
    g   = (v == 2'b11) ? (lg ? 0 : 1) : (v[1] ? 1 : 0);
    lg  = (g == 1);
    oh  = (g == 1) ? 2'b10 : 2'b01;
    w   = we[g];
    a   = (g == 1) ? ad[2*AW-1:AW] : ad[AW-1:0];
    dat = (g == 1) ? wd[2*COLS-1:COLS] : wd[COLS-1:0];
    last = w ? int'(COLS*BC) + 2 : ((d == 0) ? int'(RT) + 2 : d + 2);

    req_valid = v; req_we = we; req_addr = ad; req_wdata = wd;
    sram_data_valid = 1'b0;
    sram_data_out = rv;

    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 2'b00;
      if (w) begin
        e_sh   = (k <= int'(COLS*BC));
        idx    = int'(COLS) - 1 - (k - 1) / int'(BC);
        e_ser  = e_sh ? dat[idx] : 1'b0;
        e_wen  = (k == int'(COLS*BC) + 1);
        e_ren  = 1'b0;
        e_rspv = (k == last) ? oh : 2'b00;
        e_rd   = '0;
        e_err  = 1'b0;
      end else begin
        e_sh   = 1'b0;
        e_ser  = 1'b0;
        e_wen  = 1'b0;
        e_ren  = (k == 1);
        e_rspv = (k == last) ? oh : 2'b00;
        e_rd   = (k == last && d != 0) ? rv : '0;
        e_err  = (k == last && d == 0);
      end
      chk("ready", 32'(req_ready), (k == 1) ? 32'(oh) : 0);
      chk("shift", 32'(sram_shift), 32'(e_sh));
      chk("serial", 32'(sram_serial_in), 32'(e_ser));
      chk("w_en", 32'(sram_w_en), 32'(e_wen));
      chk("r_en", 32'(sram_r_en), 32'(e_ren));
      chk("addr", 32'(sram_addr), 32'(a));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rspv));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
      chk("busy", 32'(busy), 1);
      // drive data_valid to be sampled at the end of this cycle
      if (w) begin
        sram_data_valid = noise && (k <= int'(COLS*BC)) && ($urandom_range(0, 2) == 0);
        sram_data_out   = COLS'($urandom);
      end else begin
        sram_data_valid = (d != 0) && (k == d + 1);
      end
    end
    sram_data_valid = 1'b0;
    @(negedge clk);
    chk("end_busy", 32'(busy), 0);
    chk("end_rspv", 32'(rsp_valid), 0);
    chk("end_rdata", 32'(rsp_rdata), 0);
    chk("end_err", 32'(rsp_err), 0);
  endtask

  initial begin
    arst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    sram_data_valid = 1'b0; sram_data_out = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    arst = 1'b0;
    lg = 1'b1;

    // both requesters hold reads from reset: grants must alternate 01,10,01,10
    for (int i = 0; i < 4; i++)
      run_txn(2'b11, 2'b00, {3'd5, 3'd2}, '0, 1, COLS'($urandom), 1'b0);

    // req0 write addr=1 data=9D
    run_txn(2'b01, 2'b01, {3'd0, 3'd1}, {8'h00, 8'h9D}, 0, '0, 1'b0);
    // req1 read addr=1, reply two cycles after r_en
    run_txn(2'b10, 2'b00, {3'd1, 3'd0}, '0, 2, 8'h9D, 1'b0);
    // read timeout, then a normal write
    run_txn(2'b01, 2'b00, {3'd0, 3'd4}, '0, 0, 8'h5A, 1'b0);
    run_txn(2'b10, 2'b10, {3'd6, 3'd0}, {8'h3C, 8'h00}, 0, '0, 1'b0);
    // reply on the first and on the last counted WAIT cycle
    run_txn(2'b01, 2'b00, {3'd0, 3'd3}, '0, 1, 8'hC3, 1'b0);
    run_txn(2'b10, 2'b00, {3'd2, 3'd0}, '0, int'(RT), 8'h77, 1'b0);

    // data_valid in IDLE is ignored
    sram_data_valid = 1'b1; sram_data_out = 8'hFF;
    @(negedge clk);
    sram_data_valid = 1'b0;
    chk("idle_dv_rspv", 32'(rsp_valid), 0);
    chk("idle_dv_rdata", 32'(rsp_rdata), 0);
    chk("idle_dv_busy", 32'(busy), 0);
    @(negedge clk);
    chk("idle_dv_rspv2", 32'(rsp_valid), 0);
    // data_valid during SHIFT is ignored
    run_txn(2'b01, 2'b01, {3'd0, 3'd2}, {8'h00, 8'hE1}, 0, '0, 1'b1);

    // asynchronous reset during SHIFT bit 4
    req_valid = 2'b01; req_we = 2'b01; req_addr = {3'd0, 3'd5}; req_wdata = {8'h00, 8'hFF};
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      req_valid = 2'b00;
    end
    chk("pre_arst_shift", 32'(sram_shift), 1);
    arst = 1'b1;
    #1;
    chk_all_zero("arst");
    @(negedge clk);
    arst = 1'b0;
    lg = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_arst_rspv", 32'(rsp_valid), 0);
      chk("post_arst_busy", 32'(busy), 0);
    end
    run_txn(2'b01, 2'b01, {3'd0, 3'd7}, {8'h00, 8'hA5}, 0, '0, 1'b0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(1, 3));
      run_txn(v, 2'($urandom), 6'($urandom), 16'($urandom),
              int'($urandom_range(0, RT)), COLS'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
